// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types, default widths and helpers for the instruction fetch unit.
package ifetch_pkg;
  localparam int DEF_DEPTH  = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
    logic                  filled;
  } fetch_entry_t;
  typedef enum logic {IF_RUN, IF_DRAIN} ifetch_state_t;
  function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: in-order circular buffer of fetch entries; allocated at tail, filled
// oldest-unfilled-first, popped at head, cleared wholesale on redirect.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              clear,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              pop,
  output fetch_entry_t      head,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     unfilled
);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] hd, tl, fp;
  assign head = mem[hd];
  // Responses return in order, so fp always points at the oldest unfilled entry.
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      hd       <= '0;
      tl       <= '0;
      fp       <= '0;
      count    <= '0;
      unfilled <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      hd       <= '0;
      tl       <= '0;
      fp       <= '0;
      count    <= '0;
      unfilled <= '0;
    end else begin
      if (alloc) begin
        mem[tl] <= '{pc: DEF_ADDR_W'(alloc_pc), instr: '0, filled: 1'b0};
        tl      <= tl + PW'(1);
      end
      if (fill) begin
        mem[fp].instr  <= DEF_DATA_W'(fill_data);
        mem[fp].filled <= 1'b1;
        fp             <= fp + PW'(1);
      end
      if (pop) hd <= hd + PW'(1);
      count    <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill);
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: accepts fetch PCs, issues them to imem and delivers (instr, pc) to decode in order.
// Optional IFETCH_STATS_EN adds saturating stat_issued / stat_dropped counters.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              flush
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_dropped
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  ifetch_state_t state, state_nx;
  logic [CW-1:0] drop_cnt, drop_nx, count, unfilled;
  fetch_entry_t head;
  logic issue_ok, issue, pop, rsp_hit, fill;
  // Gating with clr_n keeps every handshake output low while reset is held.
  assign issue_ok       = clr_n && state == IF_RUN && !flush && count < CW'(DEPTH);
  assign imem_req_valid = pc_valid && issue_ok;
  assign pc_ready       = imem_req_ready && issue_ok;
  assign issue          = pc_valid && pc_ready;
  assign imem_addr      = pc_in;
  assign id_valid       = count != '0 && head.filled;
  assign id_instr       = DATA_W'(head.instr);
  assign id_pc          = ADDR_W'(head.pc);
  assign pop            = id_valid && id_ready && !flush;
  assign rsp_hit        = imem_rsp_valid && state == IF_RUN && unfilled != '0;
  assign fill           = rsp_hit && !flush;
  ifetch_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
    .clk      (clk),
    .clr_n    (clr_n),
    .clear    (flush),
    .alloc    (issue),
    .alloc_pc (pc_in),
    .fill     (fill),
    .fill_data(imem_rsp_data),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .unfilled (unfilled)
  );
  // A response landing in the flush cycle is dropped at once and not counted as pending.
  always_comb begin
    state_nx = state;
    drop_nx  = drop_cnt;
    if (state == IF_DRAIN) begin
      drop_nx  = drop_cnt - CW'(imem_rsp_valid);
      state_nx = drop_nx == '0 ? IF_RUN : IF_DRAIN;
    end else if (flush) begin
      drop_nx  = unfilled - CW'(rsp_hit);
      state_nx = drop_nx == '0 ? IF_RUN : IF_DRAIN;
    end
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state    <= IF_RUN;
      drop_cnt <= '0;
    end else begin
      state    <= state_nx;
      drop_cnt <= drop_nx;
    end
`ifdef IFETCH_STATS_EN
  logic [31:0] drop_inc;
  always_comb drop_inc = (flush && state == IF_RUN ? 32'(count - unfilled) : '0)
                       + 32'(state == IF_DRAIN ? imem_rsp_valid : flush && rsp_hit);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      stat_issued  <= '0;
      stat_dropped <= '0;
    end else begin
      stat_issued  <= sat_add(stat_issued, 32'(issue));
      stat_dropped <= sat_add(stat_dropped, drop_inc);
    end
`endif
  rsp_expected: assert property (@(posedge clk) disable iff (!clr_n)
    imem_rsp_valid |-> (unfilled != '0 || drop_cnt != '0));
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: table-driven and directed checks of ifetch_unit against a fixed-latency memory model.
module tb_ifetch_unit;
  import ifetch_pkg::*;
  logic        clk = 0, clr_n = 0;
  logic [31:0] pc_in = 0, imem_addr, imem_rsp_data = 0, id_instr, id_pc;
  logic        pc_valid = 0, pc_ready, imem_req_valid, imem_req_ready = 1;
  logic        imem_rsp_valid = 0, id_valid, id_ready = 1, flush = 0;
`ifdef IFETCH_STATS_EN
  logic [31:0] stat_issued, stat_dropped, si0, sd0;
`endif
  int tests = 0, fails = 0, cyc = 0, lat = 1;
  always #5 clk = ~clk;
  ifetch_unit dut (
    .clk(clk), .clr_n(clr_n), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .flush(flush)
`ifdef IFETCH_STATS_EN
    , .stat_issued(stat_issued), .stat_dropped(stat_dropped)
`endif
  );
  typedef struct { logic [31:0] data; int due; } rsp_t;
  rsp_t pend[$];
  typedef struct {
    logic pv; logic [31:0] pc; logic idr;
    logic pr; logic rv; logic iv; logic [31:0] ipc; logic [31:0] ins;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(bit pv, int pc, bit idr, bit pr, bit rv, bit iv, int ipc);
    return '{pv, pc, idr, pr, rv, iv, ipc, 32'h1000 + ipc};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // One clock: capture the request handshake, then present this cycle's memory response.
  task automatic step();
    logic cap;
    logic [31:0] cap_addr;
    @(negedge clk);
    cap      = imem_req_valid && imem_req_ready;
    cap_addr = imem_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (cap) pend.push_back('{32'h1000 + cap_addr, cyc - 1 + lat});
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = pend[0].data;
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data  = 0;
    end
  endtask
  task automatic run_rows(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      pc_valid = tbl[i].pv;
      pc_in    = tbl[i].pc;
      id_ready = tbl[i].idr;
      #1;
      chk($sformatf("row%0d pc_ready", i), pc_ready, tbl[i].pr);
      chk($sformatf("row%0d req_valid", i), imem_req_valid, tbl[i].rv);
      chk($sformatf("row%0d id_valid", i), id_valid, tbl[i].iv);
      if (tbl[i].rv) chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].pc);
      if (tbl[i].iv) begin
        chk($sformatf("row%0d id_pc", i), id_pc, tbl[i].ipc);
        chk($sformatf("row%0d id_instr", i), id_instr, tbl[i].ins);
      end
      step();
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    // Rows 0-6: three back-to-back fetches; rows 7-15: decode stall fills the buffer.
    tbl.push_back(v(1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, 1, 1, 0, 0));
    tbl.push_back(v(1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 2, 1, 1, 1, 1, 1));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 1, 2));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 'h10, 0, 1, 1, 0, 0));
    tbl.push_back(v(1, 'h11, 0, 1, 1, 0, 0));
    tbl.push_back(v(1, 'h12, 0, 0, 0, 1, 'h10));
    tbl.push_back(v(1, 'h12, 0, 0, 0, 1, 'h10));
    tbl.push_back(v(1, 'h12, 1, 0, 0, 1, 'h10));
    tbl.push_back(v(1, 'h12, 1, 1, 1, 1, 'h11));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 1, 'h12));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 0));
    pc_valid = 1;
    #2;
    chk("reset pc_ready", pc_ready, 0);
    chk("reset req_valid", imem_req_valid, 0);
    chk("reset id_valid", id_valid, 0);
    @(posedge clk);
    #1;
    clr_n = 1;
    run_rows(0, 15);
    // Flush with two requests in flight at 3-cycle latency.
    lat = 3;
`ifdef IFETCH_STATS_EN
    si0 = stat_issued;
    sd0 = stat_dropped;
`endif
    pc_valid = 1; pc_in = 'h20; id_ready = 1;
    #1 chk("t3 issue0 pc_ready", pc_ready, 1);
    step();
    pc_in = 'h21;
    #1 chk("t3 issue1 pc_ready", pc_ready, 1);
    step();
    pc_valid = 0; flush = 1;
    #1 chk("t3 flush pc_ready", pc_ready, 0);
    step();
    flush = 0; pc_valid = 1; pc_in = 'h40;
    #1;
    chk("t3 state drain", 32'(dut.state), 32'(IF_DRAIN));
    chk("t3 drop_cnt 2", 32'(dut.drop_cnt), 2);
    chk("t3 drain pc_ready", pc_ready, 0);
    chk("t3 drain req_valid", imem_req_valid, 0);
    chk("t3 drain id_valid", id_valid, 0);
    step();
    #1;
    chk("t3 drop_cnt 1", 32'(dut.drop_cnt), 1);
    chk("t3 drain2 pc_ready", pc_ready, 0);
    chk("t3 drain2 id_valid", id_valid, 0);
    step();
    #1;
    chk("t3 state run", 32'(dut.state), 32'(IF_RUN));
    chk("t3 run pc_ready", pc_ready, 1);
    chk("t3 run id_valid", id_valid, 0);
    step();
    pc_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t3 wait%0d id_valid", i), id_valid, 0);
      step();
    end
    #1;
    chk("t3 deliver id_valid", id_valid, 1);
    chk("t3 deliver id_pc", id_pc, 'h40);
    chk("t3 deliver id_instr", id_instr, 'h1040);
    step();
`ifdef IFETCH_STATS_EN
    chk("t3 stat_issued", stat_issued - si0, 3);
    chk("t3 stat_dropped", stat_dropped - sd0, 2);
    sd0 = stat_dropped;
`endif
    // Flush coinciding with the response for the only outstanding entry.
    lat = 1;
    pc_valid = 1; pc_in = 'h50;
    #1 chk("t4 issue pc_ready", pc_ready, 1);
    step();
    pc_in = 'h51; flush = 1;
    #1;
    chk("t4 flush rsp_valid seen", imem_rsp_valid, 1);
    chk("t4 flush pc_ready", pc_ready, 0);
    chk("t4 flush id_valid", id_valid, 0);
    step();
    flush = 0;
    #1;
    chk("t4 state run", 32'(dut.state), 32'(IF_RUN));
    chk("t4 drop_cnt 0", 32'(dut.drop_cnt), 0);
    chk("t4 next pc_ready", pc_ready, 1);
    chk("t4 no id_valid", id_valid, 0);
    step();
    pc_valid = 0;
    #1 chk("t4 wait id_valid", id_valid, 0);
    step();
    #1;
    chk("t4 deliver id_valid", id_valid, 1);
    chk("t4 deliver id_pc", id_pc, 'h51);
    chk("t4 deliver id_instr", id_instr, 'h1051);
    step();
`ifdef IFETCH_STATS_EN
    chk("t4 stat_dropped", stat_dropped - sd0, 1);
`endif
    // Reset asserted while draining.
    lat = 3;
    pc_valid = 1; pc_in = 'h60;
    step();
    pc_in = 'h61;
    step();
    pc_valid = 0; flush = 1;
    step();
    flush = 0;
    chk("t5 state drain", 32'(dut.state), 32'(IF_DRAIN));
    pc_valid = 1; pc_in = 'h70; id_ready = 1;
    clr_n = 0;
    pend.delete();
    imem_rsp_valid = 0;
    #1;
    chk("t5 rst pc_ready", pc_ready, 0);
    chk("t5 rst req_valid", imem_req_valid, 0);
    chk("t5 rst id_valid", id_valid, 0);
    chk("t5 rst state", 32'(dut.state), 32'(IF_RUN));
    chk("t5 rst drop_cnt", 32'(dut.drop_cnt), 0);
`ifdef IFETCH_STATS_EN
    chk("t5 rst stat_issued", stat_issued, 0);
    chk("t5 rst stat_dropped", stat_dropped, 0);
`endif
    step();
    step();
    pc_valid = 0;
    lat = 1;
    clr_n = 1;
    run_rows(0, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
